trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the single-cycle RISC-V core. Consumes the decoder's `SCAUSE` exception code, an `mret` strobe and an external interrupt line, and owns the trap CSRs (`mstatus`, `mie`, `mip`, `mtvec`, `mepc`, `mcause`). On a trap or return it stalls the PC, updates the CSRs, and issues a one-cycle PC redirect that the NPC mux takes in place of `PC+4`.

---
 rtl/trap_ctrl_pkg.sv | 39 +++
 rtl/trap_ctrl_if.sv | 26 ++
 rtl/trap_ctrl_sync2.sv | 22 ++
 rtl/trap_ctrl.sv | 121 ++++++++++++
 tb/tb_trap_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared encodings for the machine-mode trap sequencer
package trap_ctrl_pkg;

    localparam logic [7:0] SCAUSE_NOP           = 8'h00;
    localparam logic [7:0] SCAUSE_ILLEGAL_INSTR = 8'h02;
    localparam logic [7:0] SCAUSE_ECALL         = 8'h0B;

    localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0800;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTER  = 2'd1;
    localparam logic [1:0] ST_RETURN = 2'd2;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_EXC  = 2'd1,
        REQ_MRET = 2'd2,
        REQ_IRQ  = 2'd3
    } trap_req_t;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - core-side instruction, CSR and redirect signals of trap_ctrl
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic        instr_valid;
    logic [31:0] pc_in;
    logic [7:0]  scause_in;
    logic        mret_in;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] trap_pc;

    modport master (
        output instr_valid, pc_in, scause_in, mret_in, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, stall, redirect, trap_pc
    );

    modport slave (
        input  instr_valid, pc_in, scause_in, mret_in, csr_we, csr_addr, csr_wdata,
        output csr_rdata, stall, redirect, trap_pc
    );
endinterface

// File: rtl/trap_ctrl_sync2.sv
// rtl/trap_ctrl_sync2.sv - two-flop synchronizer for the external interrupt line
module trap_ctrl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer owning mstatus/mie/mip/mtvec/mepc/mcause
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    trap_ctrl_if.slave  bus
);
    logic [1:0]  r_state;
    logic [31:0] r_mstatus;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;

    logic        w_irq_sync;
    logic        w_irq_pend;
    trap_req_t   w_req_kind;
    logic        w_req;
    logic        w_busy;
    logic [31:0] w_trap_pc;
    logic [31:0] w_rdata;

    trap_ctrl_sync2 u_irq_sync (
        .clk (clk),
        .rst (rst),
        .i_d (ext_irq),
        .o_q (w_irq_sync)
    );

    assign w_irq_pend = w_irq_sync & r_mstatus[MSTATUS_MIE] & r_mie[MIE_MEIE];
    assign w_busy     = (r_state != ST_IDLE);

    // Exception beats mret beats interrupt; only a real instruction in IDLE can request.
    always_comb begin
        w_req_kind = REQ_NONE;
        if (!w_busy && bus.instr_valid) begin
            if (bus.scause_in != SCAUSE_NOP) begin
                w_req_kind = REQ_EXC;
            end else if (bus.mret_in) begin
                w_req_kind = REQ_MRET;
            end else if (w_irq_pend) begin
                w_req_kind = REQ_IRQ;
            end
        end
    end

    assign w_req = (w_req_kind != REQ_NONE);

    always_comb begin
        w_trap_pc = 32'h0;
        case (r_state)
            ST_ENTER:  w_trap_pc = align4(r_mtvec);
            ST_RETURN: w_trap_pc = r_mepc;
            default:   w_trap_pc = 32'h0;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        case (bus.csr_addr)
            CSR_MSTATUS: w_rdata = r_mstatus;
            CSR_MIE:     w_rdata = r_mie;
            CSR_MTVEC:   w_rdata = r_mtvec;
            CSR_MEPC:    w_rdata = r_mepc;
            CSR_MCAUSE:  w_rdata = r_mcause;
            CSR_MIP:     w_rdata = {20'h0, w_irq_sync, 11'h0};
            default:     w_rdata = 32'h0;
        endcase
    end

    // Gating with rst keeps the combinational outputs at their reset values while reset is held.
    assign bus.stall     = ~rst & (w_busy | w_req);
    assign bus.redirect  = ~rst & w_busy;
    assign bus.trap_pc   = rst ? 32'h0 : w_trap_pc;
    assign bus.csr_rdata = w_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mstatus <= 32'h0;
            r_mie     <= 32'h0;
            r_mtvec   <= align4(MTVEC_RESET);
            r_mepc    <= 32'h0;
            r_mcause  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    case (w_req_kind)
                        REQ_EXC, REQ_IRQ: begin
                            r_state   <= ST_ENTER;
                            r_mepc    <= align4(bus.pc_in);
                            r_mcause  <= (w_req_kind == REQ_IRQ) ? MCAUSE_EXT_IRQ
                                                                 : {24'h0, bus.scause_in};
                            r_mstatus <= {24'h0, r_mstatus[MSTATUS_MIE], 7'h0};
                        end
                        REQ_MRET: begin
                            r_state   <= ST_RETURN;
                            r_mstatus <= {24'h0, 1'b1, 3'h0, r_mstatus[MSTATUS_MPIE], 3'h0};
                        end
                        default: begin
                            if (bus.csr_we) begin
                                case (bus.csr_addr)
                                    CSR_MSTATUS: r_mstatus <= bus.csr_wdata & MSTATUS_WMASK;
                                    CSR_MIE:     r_mie     <= bus.csr_wdata & MIE_WMASK;
                                    CSR_MTVEC:   r_mtvec   <= align4(bus.csr_wdata);
                                    CSR_MEPC:    r_mepc    <= align4(bus.csr_wdata);
                                    default:     ;
                                endcase
                            end
                        end
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized self-checking bench for trap_ctrl against a CSR-level model
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ext_irq = 1'b0;
    logic irq_lvl = 1'b0;

    trap_ctrl_if bus();

    trap_ctrl #(.MTVEC_RESET(32'h0000_0100)) dut (
        .clk     (clk),
        .rst     (rst),
        .ext_irq (ext_irq),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_target;
    bit          m_redir;
    bit          m_irq_hist [2];

    function automatic void m_reset();
        m_mstatus = 32'h0; m_mie = 32'h0; m_mtvec = 32'h100;
        m_mepc = 32'h0; m_mcause = 32'h0; m_target = 32'h0;
        m_redir = 1'b0; m_irq_hist[0] = 1'b0; m_irq_hist[1] = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_irq_hist[1] ? 32'h800 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_req();
        bit pend;
        pend = m_irq_hist[1] && m_mstatus[3] && m_mie[11];
        return !m_redir && bus.instr_valid && (bus.scause_in != 8'h00 || bus.mret_in || pend);
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc, input logic [7:0] sc, input bit mr,
                         input bit we, input logic [11:0] a, input logic [31:0] wd);
        bit exp_stall;
        @(negedge clk);
        bus.instr_valid = v; bus.pc_in = pc; bus.scause_in = sc; bus.mret_in = mr;
        bus.csr_we = we; bus.csr_addr = a; bus.csr_wdata = wd;
        ext_irq = irq_lvl;
        #1;
        exp_stall = rst ? 1'b0 : (m_redir || m_req());
        check("m_stall", 32'(bus.stall), 32'(exp_stall));
        check("m_redirect", 32'(bus.redirect), (rst || !m_redir) ? 32'h0 : 32'h1);
        check("m_trap_pc", bus.trap_pc, (rst || !m_redir) ? 32'h0 : m_target);
        check("m_rdata", bus.csr_rdata, m_read(a));
    endtask

    task automatic idle(input logic [11:0] a);
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, a, 32'h0);
    endtask

    task automatic tick();
        bit req;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            req = m_req();
            if (m_redir) begin
                m_redir = 1'b0;
            end else if (req) begin
                m_redir = 1'b1;
                if (bus.scause_in == 8'h00 && bus.mret_in) begin
                    m_target  = m_mepc;
                    m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
                end else begin
                    m_target  = m_mtvec;
                    m_mepc    = bus.pc_in & ~32'h3;
                    m_mcause  = (bus.scause_in != 8'h00) ? {24'h0, bus.scause_in} : 32'h8000_000B;
                    m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
                end
            end else if (bus.csr_we) begin
                case (bus.csr_addr)
                    12'h300: m_mstatus = bus.csr_wdata & 32'h88;
                    12'h304: m_mie     = bus.csr_wdata & 32'h800;
                    12'h305: m_mtvec   = bus.csr_wdata & ~32'h3;
                    12'h341: m_mepc    = bus.csr_wdata & ~32'h3;
                    default: ;
                endcase
            end
            m_irq_hist[1] = m_irq_hist[0];
            m_irq_hist[0] = ext_irq;
        end
    endtask

    logic [11:0] addr_tab [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h123};

    initial begin
        m_reset();
        rst = 1'b1;
        idle(12'h305); tick();
        idle(12'h305); tick();
        #2 rst = 1'b0;

        idle(12'h305);
        check("rst_mtvec", bus.csr_rdata, 32'h100);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_redirect", 32'(bus.redirect), 32'h0);
        check("rst_trap_pc", bus.trap_pc, 32'h0);
        tick();

        drive(1'b1, 32'h40, 8'h0B, 1'b0, 1'b0, 12'h0, 32'h0);
        check("ecall_stall_T", 32'(bus.stall), 32'h1);
        tick();
        idle(12'h341);
        check("ecall_redirect", 32'(bus.redirect), 32'h1);
        check("ecall_trap_pc", bus.trap_pc, 32'h100);
        check("ecall_mepc", bus.csr_rdata, 32'h40);
        tick();
        idle(12'h342); check("ecall_mcause", bus.csr_rdata, 32'hB); tick();
        idle(12'h300); check("ecall_mstatus", bus.csr_rdata, 32'h0); tick();

        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 12'h300, 32'h8); tick();
        drive(1'b1, 32'h80, 8'h02, 1'b0, 1'b0, 12'h0, 32'h0); tick();
        idle(12'h342); tick();
        idle(12'h342); check("ill_mcause", bus.csr_rdata, 32'h2); tick();
        idle(12'h300); check("ill_mstatus", bus.csr_rdata, 32'h80); tick();
        drive(1'b1, 32'h84, 8'h00, 1'b1, 1'b0, 12'h0, 32'h0);
        check("mret_stall", 32'(bus.stall), 32'h1);
        tick();
        idle(12'h300);
        check("mret_redirect", 32'(bus.redirect), 32'h1);
        check("mret_trap_pc", bus.trap_pc, 32'h80);
        check("mret_mstatus", bus.csr_rdata, 32'h88);
        tick();

        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 12'h305, 32'h203); tick();
        idle(12'h305); check("mtvec_warl", bus.csr_rdata, 32'h200); tick();
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 12'h344, 32'hFFFF_FFFF); tick();
        idle(12'h344); check("mip_ro", bus.csr_rdata, 32'h0); tick();
        drive(1'b1, 32'h44, 8'h0B, 1'b0, 1'b1, 12'h341, 32'hDEAD_0000); tick();
        idle(12'h341); check("race_trap_pc", bus.trap_pc, 32'h200); tick();
        idle(12'h341); check("race_mepc", bus.csr_rdata, 32'h44); tick();

        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 12'h304, 32'hFFFF_FFFF); tick();
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 12'h300, 32'h8); tick();
        irq_lvl = 1'b1;
        drive(1'b1, 32'h100, 8'h00, 1'b0, 1'b0, 12'h0, 32'h0);
        check("irq_edge1", 32'(bus.stall), 32'h0); tick();
        drive(1'b1, 32'h104, 8'h00, 1'b0, 1'b0, 12'h0, 32'h0);
        check("irq_edge2", 32'(bus.stall), 32'h0); tick();
        drive(1'b1, 32'h108, 8'h00, 1'b0, 1'b0, 12'h0, 32'h0);
        check("irq_edge3", 32'(bus.stall), 32'h1); tick();
        idle(12'h342); check("irq_mcause", bus.csr_rdata, 32'h8000_000B); tick();
        idle(12'h344); check("irq_mip", bus.csr_rdata, 32'h800); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 8'h00, 1'b0, 1'b0, 12'h0, 32'h0);
            check("irq_masked", 32'(bus.stall), 32'h0);
            tick();
        end
        irq_lvl = 1'b0;

        drive(1'b1, 32'h60, 8'h0B, 1'b0, 1'b0, 12'h0, 32'h0); tick();
        idle(12'h341);
        check("rst_mid_pre", 32'(bus.redirect), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_redirect", 32'(bus.redirect), 32'h0);
        check("rst_mid_trap_pc", bus.trap_pc, 32'h0);
        check("rst_mid_stall", 32'(bus.stall), 32'h0);
        m_reset();
        tick();
        idle(12'h341); tick();
        #2 rst = 1'b0;
        idle(12'h341); check("rst_mid_mepc", bus.csr_rdata, 32'h0); tick();

        for (int i = 0; i < 800; i++) begin
            int r;
            logic [7:0] sc;
            if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
            r = $urandom_range(0, 15);
            sc = (r == 0) ? 8'h02 : (r == 1) ? 8'h0B : (r == 2) ? 8'($urandom) : 8'h00;
            drive($urandom_range(0, 3) != 0, $urandom, sc, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, addr_tab[$urandom_range(0, 6)], $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
